instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Host-side instruction issuer for the 16-bit-instruction processor core; the producing end of the core's instruction/result interface.
- A program of up to DEPTH instruction words is loaded byte-serially, then issued to the core one word per cycle.
- The core's 8-bit ALU result and zero flag are captured for every issued word into a result buffer that is readable afterwards.

Parameters:
- ADDR_W, 4, program/result buffer address width; DEPTH = 2**ADDR_W words.
- HALT_OP, 3'b111, opcode field (instr[2:0]) that terminates a run. The halt word is not issued.

Ports:
- clk  in  1  clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- ld_valid  in  1  load byte strobe
- ld_byte  in  8  load data; low byte first, then high byte
- ld_ready  out  1  load accepted this cycle
- ld_clear  in  1  discard loaded program (count:=0, byte phase:=low)
- start  in  1  begin run (pulse)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- instr  out  16  instruction word to core
- instr_valid  out  1  instr is live this cycle
- alu_result  in  8  core result for the current instr (combinational in core)
- alu_zero  in  1  core zero flag
- prog_count  out  ADDR_W+1  words loaded
- res_count  out  ADDR_W+1  results captured in last run
- zero_count  out  ADDR_W+1  captured results with alu_zero=1
- rd_addr  in  ADDR_W  result read address
- rd_data  out  8  result at rd_addr (combinational); 0 if rd_addr >= res_count
- rd_zero  out  1  zero flag at rd_addr; 0 if rd_addr >= res_count

Behaviour:
- Reset values: state IDLE; busy=0, done=0, instr_valid=0, instr=16'h0000; prog_count=0, res_count=0, zero_count=0; byte phase low. Buffers are not reset; they are gated by the counts.
- Idle-cycle instr output: whenever instr_valid=0, instr=16'h0000 (opcode 000, so the core performs no register write).
- States: IDLE, RUN, DONE.
- Load (IDLE only):
  - ld_ready = (state==IDLE) && (prog_count<DEPTH) && !start && !ld_clear.
  - On ld_valid && ld_ready: in low phase, latch the byte and set phase high. In high phase, write {ld_byte, low} to prog[prog_count], increment prog_count, set phase low.
  - ld_valid with ld_ready=0 is ignored.
  - ld_clear in IDLE: prog_count:=0, phase:=low. ld_clear is ignored in RUN/DONE.
- start in IDLE:
  - Next state RUN; pc:=0, res_count:=0, zero_count:=0, and a pending low byte is discarded.
  - start outranks ld_valid in the same cycle.
  - start in RUN or DONE is ignored.
- RUN, per cycle, with w = prog[pc]:
  - If pc==prog_count or w[2:0]==HALT_OP: instr_valid=0, next state DONE.
  - Otherwise: instr=w, instr_valid=1. At the clock edge, res[pc]:={alu_zero, alu_result}, res_count++, zero_count += alu_zero, pc++.
  - Throughput: one word per cycle, no stalls.
  - Latency: first issue is in the cycle after start. N words give N issue cycles, then 1 terminating cycle, then DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy = (state==RUN).
- Empty program (prog_count=0): start produces RUN for 1 cycle with no issue, then DONE; res_count=0.
- Full program: pc wraps only by reaching prog_count=DEPTH; pc is ADDR_W+1 bits, so there is no aliasing.
- Reset mid-run:
  - instr_valid=0 the next cycle, no done pulse.
  - All counts are 0 afterwards, so the program must be reloaded.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/RUN/DONE)
  - HALT_OP default
  - instruction field positions: opcode [2:0], func [6:3], reg2 [9:7], reg1 [12:10], regw [15:13]
  - the no-op instruction 16'h0000
- One sub-module: seq_buffer, a generic DEPTH x W synchronous-write, asynchronous-read array. It is instantiated twice: program (W=16) and result (W=9).

Test Plan:
- Load bytes 0x34,0x12,0xCD,0xAB (prog_count=2), start. Required: cycle+1 instr=0x1234/valid; cycle+2 instr=0xABCD/valid; cycle+3 valid=0; cycle+4 done=1. With the bench driving alu_result=0x05 then 0x00: rd_addr=0 gives 0x05/zero=0, rd_addr=1 gives 0x00/zero=1; res_count=2, zero_count=1.
- Load 0x0001, 0x0007, 0x0002, start. Required: only 0x0001 issued; halt word never on instr; res_count=1; done after 3 cycles.
- Load 33 bytes 0x00..0x20. Required: prog_count=16; ld_ready=0 from the 32nd accepted byte onward; byte 0x20 ignored.
- ld_clear, then start with prog_count=0. Required: instr_valid stays 0; done pulses 2 cycles after start; res_count=0; rd_data=0 for all addresses.
- Load 4 words, start, assert rst on the 2nd issue cycle. Required: next cycle instr_valid=0, instr=0x0000, busy=0; no done; all counts 0.
- Load one low byte 0x11, then start and ld_valid together. Required: byte discarded; after the run a new pair 0x22,0x33 loads word 0x3322 at prog index prog_count.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM encoding, instruction
// field layout of the 16-bit core and the no-op word driven while idle.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] HALT_OP_DEFAULT = 3'b111;

  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 2;
  localparam int FUNC_LSB = 3;
  localparam int FUNC_MSB = 6;
  localparam int REG2_LSB = 7;
  localparam int REG2_MSB = 9;
  localparam int REG1_LSB = 10;
  localparam int REG1_MSB = 12;
  localparam int REGW_LSB = 13;
  localparam int REGW_MSB = 15;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  function automatic logic [2:0] opcode_of(input logic [15:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_sequencer_seq_buffer.sv
// Generic DEPTH x W storage: synchronous write, asynchronous read, no reset
// (contents are qualified by the owner's counters).
module seq_buffer #(
  parameter int AW = 4,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [2**AW];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Host-side instruction issuer: byte-serial program load, one-word-per-cycle
// issue to the core, and capture of the core's result/zero flag per word.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int         ADDR_W  = 4,
  parameter logic [2:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  input  logic              ld_clear,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic [7:0]        alu_result,
  input  logic              alu_zero,
  output logic [ADDR_W:0]   prog_count,
  output logic [ADDR_W:0]   res_count,
  output logic [ADDR_W:0]   zero_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_zero
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] pc_q, pc_d;
  logic [ADDR_W:0] prog_count_q, prog_count_d;
  logic [ADDR_W:0] res_count_q, res_count_d;
  logic [ADDR_W:0] zero_count_q, zero_count_d;
  logic            phase_q, phase_d;
  logic [7:0]      low_q, low_d;
  logic [15:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            ld_ready_s;
  logic            prog_we_s;
  logic [15:0]     prog_rdata_s;
  logic            res_we_s;
  logic [8:0]      res_rdata_s;
  logic            issue_s;
  logic            rd_hit_s;

  assign ld_ready_s = (state_q == ST_IDLE) && (prog_count_q < DEPTH_C) && !start && !ld_clear;

  // next-state, load path and result-capture bookkeeping
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    prog_count_d = prog_count_q;
    res_count_d  = res_count_q;
    zero_count_d = zero_count_q;
    phase_d      = phase_q;
    low_d        = low_q;
    prog_we_s    = 1'b0;
    res_we_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          pc_d         = '0;
          res_count_d  = '0;
          zero_count_d = '0;
          phase_d      = 1'b0;
        end else if (ld_clear) begin
          prog_count_d = '0;
          phase_d      = 1'b0;
        end else if (ld_valid && ld_ready_s) begin
          if (!phase_q) begin
            low_d   = ld_byte;
            phase_d = 1'b1;
          end else begin
            prog_we_s    = 1'b1;
            prog_count_d = prog_count_q + ONE_C;
            phase_d      = 1'b0;
          end
        end else begin
          phase_d = phase_q;
        end
      end
      ST_RUN: begin
        if (instr_valid_q) begin
          res_we_s     = 1'b1;
          res_count_d  = res_count_q + ONE_C;
          zero_count_d = zero_count_q + {{ADDR_W{1'b0}}, alu_zero};
          pc_d         = pc_q + ONE_C;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue decision looks ahead at pc_d so instr/instr_valid can be registered.
  always_comb begin
    issue_s       = (state_d == ST_RUN) && (pc_d != prog_count_d) &&
                    (opcode_of(prog_rdata_s) != HALT_OP);
    instr_valid_d = issue_s;
    instr_d       = issue_s ? prog_rdata_s : NOP_INSTR;
    busy_d        = (state_d == ST_RUN);
    done_d        = (state_d == ST_DONE);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      prog_count_q  <= '0;
      res_count_q   <= '0;
      zero_count_q  <= '0;
      phase_q       <= 1'b0;
      low_q         <= 8'h00;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      prog_count_q  <= prog_count_d;
      res_count_q   <= res_count_d;
      zero_count_q  <= zero_count_d;
      phase_q       <= phase_d;
      low_q         <= low_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  seq_buffer #(.AW(ADDR_W), .W(16)) u_prog (
    .clk   (clk),
    .we    (prog_we_s),
    .waddr (prog_count_q[ADDR_W-1:0]),
    .wdata ({ld_byte, low_q}),
    .raddr (pc_d[ADDR_W-1:0]),
    .rdata (prog_rdata_s)
  );

  seq_buffer #(.AW(ADDR_W), .W(9)) u_res (
    .clk   (clk),
    .we    (res_we_s),
    .waddr (pc_q[ADDR_W-1:0]),
    .wdata ({alu_zero, alu_result}),
    .raddr (rd_addr),
    .rdata (res_rdata_s)
  );

  assign rd_hit_s    = ({1'b0, rd_addr} < res_count_q);
  assign rd_data     = rd_hit_s ? res_rdata_s[7:0] : 8'h00;
  assign rd_zero     = rd_hit_s ? res_rdata_s[8] : 1'b0;
  assign ld_ready    = ld_ready_s;
  assign busy        = busy_q;
  assign done        = done_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign prog_count  = prog_count_q;
  assign res_count   = res_count_q;
  assign zero_count  = zero_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a scoreboard of expected issued
// words plus a stand-in core that answers each issue, and table-driven loading.
module tb_instr_sequencer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_byte = 8'h00;
  logic          ld_ready;
  logic          ld_clear = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [15:0]   instr;
  logic          instr_valid;
  logic [7:0]    alu_result = 8'h00;
  logic          alu_zero = 1'b0;
  logic [AW:0]   prog_count, res_count, zero_count;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          rd_zero;

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_clear(ld_clear), .start(start), .busy(busy),
    .done(done), .instr(instr), .instr_valid(instr_valid),
    .alu_result(alu_result), .alu_zero(alu_zero), .prog_count(prog_count),
    .res_count(res_count), .zero_count(zero_count), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_zero(rd_zero)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  resp_q[$];
  logic [8:0]  exp_res[16];
  int          exp_rc = 0;
  int          exp_zc = 0;
  logic [15:0] model_prog[16];
  int          model_count = 0;
  logic [7:0]  mon_r;

  typedef struct {
    logic [7:0] b;
    logic       exp_ready;
    logic [4:0] exp_cnt;
  } vec_t;
  vec_t vt[33];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // stand-in core: check each issued word, answer it, record the expected capture
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_issue: got %0h, expected no issue", instr);
        end else begin
          chk("issue_word", {16'h0, instr}, {16'h0, exp_q.pop_front()});
        end
        mon_r = (resp_q.size() != 0) ? resp_q.pop_front() : instr[15:8];
        alu_result = mon_r;
        alu_zero   = (mon_r == 8'h00);
        if (exp_rc < 16) exp_res[exp_rc] = {(mon_r == 8'h00), mon_r};
        exp_rc++;
        if (mon_r == 8'h00) exp_zc++;
      end else begin
        chk("idle_nop", {16'h0, instr}, 32'h0);
      end
    end
  end

  task automatic load_word(input logic [15:0] w);
    ld_valid = 1'b1;
    ld_byte  = w[7:0];
    @(posedge clk); #1;
    ld_byte  = w[15:8];
    @(posedge clk); #1;
    ld_valid = 1'b0;
    if (model_count < 16) model_prog[model_count] = w;
    model_count++;
  endtask

  task automatic clear_prog();
    @(posedge clk); #1;
    ld_clear = 1'b1;
    @(posedge clk); #1;
    ld_clear = 1'b0;
    model_count = 0;
  endtask

  task automatic check_results(input string nm);
    chk({nm, "_res_count"}, {27'h0, res_count}, exp_rc);
    chk({nm, "_zero_count"}, {27'h0, zero_count}, exp_zc);
    for (int a = 0; a < 16; a++) begin
      rd_addr = AW'(a);
      #1;
      chk({nm, "_rd"}, {23'h0, rd_zero, rd_data},
          (a < exp_rc) ? {23'h0, exp_res[a]} : 32'h0);
    end
  endtask

  task automatic run_prog(input string nm);
    int n;
    int got;
    got = -1;
    exp_q.delete();
    for (int i = 0; i < model_count; i++) begin
      if (model_prog[i][2:0] == 3'b111) break;
      exp_q.push_back(model_prog[i]);
    end
    n = exp_q.size();
    exp_rc = 0;
    exp_zc = 0;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      ld_valid = 1'b0;
      @(negedge clk); #1;
      if (k <= n + 1) chk({nm, "_valid_pattern"}, {31'h0, instr_valid}, (k <= n) ? 32'h1 : 32'h0);
      if (k == 1) chk({nm, "_busy"}, {31'h0, busy}, 32'h1);
      if (done) begin
        got = k;
        break;
      end
    end
    chk({nm, "_done_latency"}, got, n + 2);
    @(posedge clk); #1;
    chk({nm, "_done_pulse_end"}, {30'h0, busy, done}, 32'h0);
    chk({nm, "_sb_drained"}, exp_q.size(), 0);
    check_results(nm);
    resp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flags", {28'h0, busy, done, instr_valid, ld_ready}, 32'h1);
    chk("rst_instr", {16'h0, instr}, 32'h0);
    chk("rst_counts", {17'h0, prog_count, res_count, zero_count}, 32'h0);

    // basic two-word program with explicit core answers
    @(posedge clk); #1;
    load_word(16'h1234);
    load_word(16'hABCD);
    chk("t1_prog_count", {27'h0, prog_count}, 32'd2);
    resp_q.push_back(8'h05);
    resp_q.push_back(8'h00);
    run_prog("t1");
    chk("t1_counts", {22'h0, res_count, zero_count}, {22'h0, 5'd2, 5'd1});

    // halt word ends the run and is never issued
    clear_prog();
    load_word(16'h0001);
    load_word(16'h0007);
    load_word(16'h0002);
    run_prog("halt");

    // empty program
    clear_prog();
    chk("empty_prog_count", {27'h0, prog_count}, 32'h0);
    run_prog("empty");

    // table-driven fill to capacity with one extra byte
    for (int i = 0; i < 33; i++) begin
      vt[i].b         = 8'(i);
      vt[i].exp_ready = (i < 32);
      vt[i].exp_cnt   = 5'((i + 1) / 2 > 16 ? 16 : (i + 1) / 2);
    end
    clear_prog();
    for (int i = 0; i < 33; i++) begin
      ld_valid = 1'b1;
      ld_byte  = vt[i].b;
      @(negedge clk);
      chk("fill_ld_ready", {31'h0, ld_ready}, {31'h0, vt[i].exp_ready});
      @(posedge clk); #1;
      chk("fill_prog_count", {27'h0, prog_count}, {27'h0, vt[i].exp_cnt});
      if ((i % 2 == 1) && (i < 32)) model_prog[i / 2] = {vt[i].b, vt[i - 1].b};
      model_count = int'(vt[i].exp_cnt);
    end
    ld_valid = 1'b0;
    run_prog("full");

    // pending low byte is discarded when start arrives with ld_valid
    clear_prog();
    load_word(16'h0010);
    ld_valid = 1'b1;
    ld_byte  = 8'h11;
    @(posedge clk); #1;
    ld_byte  = 8'h44;
    run_prog("discard");
    chk("discard_prog_count", {27'h0, prog_count}, 32'd1);
    @(posedge clk); #1;
    load_word(16'h3322);
    chk("discard_new_count", {27'h0, prog_count}, 32'd2);
    run_prog("discard_rerun");

    // reset in the middle of a run
    clear_prog();
    load_word(16'h0010);
    load_word(16'h0020);
    load_word(16'h0030);
    load_word(16'h0040);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(model_prog[i]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid_busy", {30'h0, instr_valid, busy}, 32'h0);
    chk("rst_mid_instr", {16'h0, instr}, 32'h0);
    begin
      int seen_done;
      seen_done = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      chk("rst_mid_no_done", seen_done, 0);
    end
    chk("rst_mid_counts", {17'h0, prog_count, res_count, zero_count}, 32'h0);
    exp_q.delete();
    model_count = 0;
    exp_rc = 0;
    exp_zc = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
